// File: rtl/bus_pkg.sv
// Shared definitions for the two-slave bus: widths, slave address map and
// the responder FSM state encoding.
package bus_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] S0_BASE  = 8'h00;
    localparam logic [ADDR_W-1:0] S1_BASE  = 8'h20;
    localparam logic [ADDR_W-1:0] SLV_SIZE = 8'h20;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    // True when addr falls in the SLV_SIZE window starting at base.
    function automatic logic addr_in_slave(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base);
        logic [ADDR_W:0] upper;
        upper = {1'b0, base} + {1'b0, SLV_SIZE};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < upper);
    endfunction

endpackage

// File: rtl/bus_slave_regfile.sv
// Register-array memory for the bus slave: synchronous write, combinational
// read, whole array cleared by synchronous reset.
module bus_slave_regfile #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_slave_mem_resp.sv
// Bus slave responder: accepts one read or write per select, waits a fixed
// number of cycles, then pulses s_ready with registered read data.
module bus_slave_mem_resp #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_sel,
    input  logic                       s_wr,
    input  logic [bus_pkg::ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0]          s_din,
    output logic                       s_ready,
    output logic [DATA_W-1:0]          s_dout
);
    import bus_pkg::*;

    localparam logic [2:0] CntInit = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic                    ready_q;
    logic [DATA_W-1:0]       dout_q;

    logic                    enter_resp;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    unused_addr;

    assign unused_addr = ^s_addr[ADDR_W-1:DEPTH_LOG2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        unique case (state_q)
            StIdle: begin
                if (s_sel) begin
                    wr_d   = s_wr;
                    addr_d = s_addr[DEPTH_LOG2-1:0];
                    din_d  = s_din;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!s_sel) begin
                    state_d = StIdle;
                end else if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The *_d latches carry the live inputs when accepting straight into RESP,
    // so the commit and the read use the same access attributes in every case.
    assign enter_resp = (state_d == StResp);
    assign mem_we     = enter_resp && wr_d;

    bus_slave_regfile #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .waddr_i (addr_d),
        .wdata_i (din_d),
        .raddr_i (addr_d),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= enter_resp;
            dout_q  <= (enter_resp && !wr_d) ? mem_rdata : '0;
        end
    end

    assign s_ready = ready_q;
    assign s_dout  = dout_q;

endmodule

// File: tb/tb_bus_slave_mem_resp.sv
// Self-checking bench for bus_slave_mem_resp: one instance with two wait
// states and one with none, checked against a per-instance memory model.
module tb_bus_slave_mem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel2, sel0;
    logic        s_wr;
    logic [7:0]  s_addr;
    logic [31:0] s_din;
    logic        rdy2, rdy0;
    logic [31:0] dout2, dout0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem2 [32];
    logic [31:0] mem0 [32];

    always #5 clk = ~clk;

    bus_slave_mem_resp #(.WAIT_STATES(2), .DATA_W(32), .DEPTH_LOG2(5)) dut (
        .clk(clk), .reset(reset), .s_sel(sel2), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_ready(rdy2), .s_dout(dout2)
    );

    bus_slave_mem_resp #(.WAIT_STATES(0), .DATA_W(32), .DEPTH_LOG2(5)) dut0 (
        .clk(clk), .reset(reset), .s_sel(sel0), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_ready(rdy0), .s_dout(dout0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/rdy2"}, {31'd0, rdy2}, 32'd0);
        chk({tag, "/dout2"}, dout2, 32'd0);
        chk({tag, "/rdy0"}, {31'd0, rdy0}, 32'd0);
        chk({tag, "/dout0"}, dout0, 32'd0);
    endtask

    // One access. lead=1 when the previous access kept select high, so the
    // slave spends one IDLE cycle before accepting. Ready is due in cycle
    // lead+WAIT_STATES+1 counted from the cycle the inputs are presented.
    task automatic run_access(input bit on0, input bit wr, input logic [7:0] addr,
                              input logic [31:0] din, input int lead, input bit keep,
                              input string tag);
        int          ws;
        int          rk;
        logic [31:0] exp_d;
        logic        o_rdy;
        logic [31:0] o_d;
        ws    = on0 ? 0 : 2;
        rk    = lead + ws + 1;
        exp_d = on0 ? mem0[addr[4:0]] : mem2[addr[4:0]];
        if (on0) sel0 = 1'b1; else sel2 = 1'b1;
        s_wr   = wr;
        s_addr = addr;
        s_din  = din;
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            o_rdy = on0 ? rdy0 : rdy2;
            o_d   = on0 ? dout0 : dout2;
            chk($sformatf("%s/rdy@%0d", tag, k), {31'd0, o_rdy}, (k == rk) ? 32'd1 : 32'd0);
            chk($sformatf("%s/dout@%0d", tag, k), o_d, (k == rk && !wr) ? exp_d : 32'd0);
            if (k > lead && k < rk) begin
                s_wr   = 1'($urandom);
                s_addr = 8'($urandom);
                s_din  = $urandom;
            end
        end
        if (wr) begin
            if (on0) mem0[addr[4:0]] = din; else mem2[addr[4:0]] = din;
        end
        if (!keep) begin
            sel2 = 1'b0;
            sel0 = 1'b0;
            @(negedge clk);
            o_rdy = on0 ? rdy0 : rdy2;
            o_d   = on0 ? dout0 : dout2;
            chk({tag, "/rdy_after"}, {31'd0, o_rdy}, 32'd0);
            chk({tag, "/dout_after"}, o_d, 32'd0);
        end
    endtask

    initial begin
        int          lead;
        bit          r_wr;
        bit          r_keep;
        logic [7:0]  r_a;
        logic [31:0] r_d;

        reset  = 1'b1;
        sel2   = 1'b0;
        sel0   = 1'b0;
        s_wr   = 1'b0;
        s_addr = 8'h00;
        s_din  = 32'h0;
        for (int i = 0; i < 32; i++) begin
            mem2[i] = 32'h0;
            mem0[i] = 32'h0;
        end

        @(negedge clk);
        chk_idle("reset1");
        @(negedge clk);
        chk_idle("reset2");
        reset = 1'b0;

        run_access(0, 0, 8'h05, 32'h0, 0, 0, "rd05_after_reset");

        run_access(0, 1, 8'h0A, 32'hDEADBEEF, 0, 0, "wr0A");
        run_access(0, 0, 8'h0A, 32'h0, 0, 0, "rd0A");

        run_access(0, 1, 8'h3F, 32'h12345678, 0, 0, "wr3F");
        run_access(0, 0, 8'h1F, 32'h0, 0, 0, "rd1F_alias");
        run_access(0, 1, 8'h20, 32'hA5A5A5A5, 0, 0, "wr20");
        run_access(0, 0, 8'h00, 32'h0, 0, 0, "rd00_alias");

        // Aborted write: select dropped during WAIT, nothing may complete.
        sel2   = 1'b1;
        s_wr   = 1'b1;
        s_addr = 8'h03;
        s_din  = 32'hFFFFFFFF;
        @(negedge clk);
        chk("abort/rdy_wait", {31'd0, rdy2}, 32'd0);
        sel2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort/rdy_%0d", k), {31'd0, rdy2}, 32'd0);
        end
        run_access(0, 0, 8'h03, 32'h0, 0, 0, "rd03_after_abort");

        // Back-to-back reads with select held: pulses at cycles 3 and 7.
        run_access(0, 1, 8'h01, 32'h11110001, 0, 0, "wr01");
        run_access(0, 1, 8'h02, 32'h22220002, 0, 0, "wr02");
        run_access(0, 0, 8'h01, 32'h0, 0, 1, "b2b_rd01");
        run_access(0, 0, 8'h02, 32'h0, 1, 0, "b2b_rd02");

        // Zero wait states: ready in the cycle after acceptance.
        run_access(1, 1, 8'h07, 32'hCAFEF00D, 0, 0, "ws0_wr07");
        run_access(1, 0, 8'h27, 32'h0, 0, 0, "ws0_rd27");
        run_access(1, 0, 8'h07, 32'h0, 0, 1, "ws0_b2b_rd07");
        run_access(1, 1, 8'h08, 32'h0BADBEEF, 1, 0, "ws0_b2b_wr08");

        lead = 0;
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom);
            r_a    = 8'($urandom);
            r_d    = $urandom;
            r_keep = (n < 39) && ($urandom_range(0, 3) == 0);
            run_access(0, r_wr, r_a, r_d, lead, r_keep, $sformatf("rnd2_%0d", n));
            lead = r_keep ? 1 : 0;
        end
        lead = 0;
        for (int n = 0; n < 20; n++) begin
            r_wr   = 1'($urandom);
            r_a    = 8'($urandom);
            r_d    = $urandom;
            r_keep = (n < 19) && ($urandom_range(0, 3) == 0);
            run_access(1, r_wr, r_a, r_d, lead, r_keep, $sformatf("rnd0_%0d", n));
            lead = r_keep ? 1 : 0;
        end

        // Reset during WAIT of a write: aborted, and memory is cleared.
        run_access(0, 1, 8'h04, 32'h44444444, 0, 0, "wr04_pre");
        sel2   = 1'b1;
        s_wr   = 1'b1;
        s_addr = 8'h04;
        s_din  = 32'h5A5A5A5A;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midreset");
        sel2  = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem2[i] = 32'h0;
            mem0[i] = 32'h0;
        end
        @(negedge clk);
        chk_idle("post_reset");
        run_access(0, 0, 8'h04, 32'h0, 0, 0, "rd04_after_reset");
        run_access(0, 0, 8'h0A, 32'h0, 0, 0, "rd0A_after_reset");
        run_access(1, 0, 8'h07, 32'h0, 0, 0, "ws0_rd07_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
